// File: rtl/dma_write_arbiter.sv
// Round-robin arbiter that shares one dma_write engine among NUM_REQ producers:
// picks a job, sequences the DMA start/done handshake and muxes the winner's stream.
module dma_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 128,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*32-1:0]           i_req_addr,
    input  logic [NUM_REQ*32-1:0]           i_req_len,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic [NUM_REQ-1:0]              o_req_done,
    output logic [NUM_REQ-1:0]              o_req_error,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_s_data,
    input  logic [NUM_REQ-1:0]              i_s_valid,
    output logic [NUM_REQ-1:0]              o_s_ready,
    output logic                            o_dma_start,
    output logic [31:0]                     o_dma_base_addr,
    output logic [31:0]                     o_dma_byte_len,
    input  logic                            i_dma_busy,
    input  logic                            i_dma_done,
    input  logic                            i_dma_error,
    output logic [DATA_WIDTH-1:0]           o_dma_data,
    output logic                            o_dma_valid,
    input  logic                            i_dma_ready,
    output logic                            o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]     grant_idx_reg, grant_idx_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [NUM_REQ-1:0]   done_reg, done_next;
    logic [NUM_REQ-1:0]   error_reg, error_next;
    logic                 busy_reg, busy_next;
    logic [31:0]          addr_reg, addr_next;
    logic [31:0]          len_reg, len_next;

    logic [31:0]            addr_arr [NUM_REQ];
    logic [31:0]            len_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
    logic [IDX_W-1:0]       cand_idx [NUM_REQ];

    logic [NUM_REQ-1:0]   req_eligible;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic                 run_active;

    // Busy from the DMA is informational only; sequencing relies on start/done.
    logic unused_dma_busy;
    assign unused_dma_busy = i_dma_busy;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            logic [IDX_W:0] rot_sum;
            assign addr_arr[gi] = i_req_addr[gi*32 +: 32];
            assign len_arr[gi]  = i_req_len[gi*32 +: 32];
            assign data_arr[gi] = i_s_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign rot_sum      = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (rot_sum >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(rot_sum - (IDX_W+1)'(NUM_REQ))
                                : rot_sum[IDX_W-1:0];
        end
    endgenerate

    // A requester whose done pulse is on this cycle may still hold i_req; masking
    // it stops a zero-length job from being re-selected before it can drop.
    assign req_eligible = i_req & ~done_reg;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_eligible[cand_idx[i]]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= '0;
            grant_idx_reg <= '0;
            grant_reg     <= '0;
            done_reg      <= '0;
            error_reg     <= '0;
            busy_reg      <= 1'b0;
            addr_reg      <= '0;
            len_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_idx_reg <= grant_idx_next;
            grant_reg     <= grant_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            busy_reg      <= busy_next;
            addr_reg      <= addr_next;
            len_reg       <= len_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_idx_next = grant_idx_reg;
        grant_next     = grant_reg;
        done_next      = '0;
        error_next     = '0;
        busy_next      = busy_reg;
        addr_next      = addr_reg;
        len_next       = len_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (win_found) begin
                    if (len_arr[win_idx] == 32'd0) begin
                        // Empty job: complete immediately without touching the DMA.
                        done_next[win_idx] = 1'b1;
                        rr_ptr_next        = wrap_inc(win_idx);
                    end else begin
                        addr_next      = addr_arr[win_idx];
                        len_next       = len_arr[win_idx];
                        grant_idx_next = win_idx;
                        grant_next     = NUM_REQ'(1) << win_idx;
                        busy_next      = 1'b1;
                        state_next     = S_START;
                    end
                end
            end
            S_START: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (i_dma_done) begin
                    done_next[grant_idx_reg]  = 1'b1;
                    error_next[grant_idx_reg] = i_dma_error;
                    grant_next                = '0;
                    busy_next                 = 1'b0;
                    rr_ptr_next               = wrap_inc(grant_idx_reg);
                    state_next                = S_GAP;
                end
            end
            S_GAP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign run_active = (state_reg == S_RUN);

    assign o_grant         = grant_reg;
    assign o_busy          = busy_reg;
    assign o_req_done      = done_reg;
    assign o_req_error     = error_reg;
    assign o_dma_base_addr = addr_reg;
    assign o_dma_byte_len  = len_reg;
    assign o_dma_start     = (state_reg == S_START);

    assign o_dma_data  = run_active ? data_arr[grant_idx_reg] : '0;
    assign o_dma_valid = run_active & i_s_valid[grant_idx_reg];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign o_s_ready[gi] = run_active && (grant_idx_reg == IDX_W'(gi)) && i_dma_ready;
        end
    endgenerate

endmodule
